// File: rtl/pkt_fifo_wr_admit.sv
// Packet-aware write-side controller: writes framed beats speculatively and
// publishes a committed pointer only for complete, error-free packets.
module pkt_fifo_wr_admit #(
  parameter int DWID          = 64,
  parameter int AWID          = 10,
  parameter int MAX_PKT_WORDS = 256,
  parameter int CWID          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic            in_sop,
  input  logic            in_eop,
  input  logic            in_err,
  input  logic [DWID-1:0] in_data,
  input  logic [AWID-1:0] raddr,
  output logic            wen,
  output logic [AWID-1:0] waddr,
  output logic [DWID-1:0] wdata,
  output logic [AWID-1:0] commit_addr,
  output logic            commit_pulse,
  output logic            drop_pulse,
  output logic [CWID-1:0] pkt_ok_cnt,
  output logic [CWID-1:0] pkt_drop_cnt,
  output logic [CWID-1:0] orphan_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  localparam logic [AWID-1:0] MAX_W = AWID'(MAX_PKT_WORDS);

  state_t          state, state_nxt;
  logic [AWID-1:0] spec_ptr, word_cnt, word_cnt_nxt, used, free;
  logic            err_flag, err_flag_nxt;
  logic            admit, eval_sop;
  logic            wr_nxt, commit_nxt, rb_late_nxt, rb_now, rej, orphan;
  logic            pend_commit, pend_rb;
  logic [1:0]      drop_inc;

  function automatic logic [CWID-1:0] sat_add(input logic [CWID-1:0] c,
                                              input logic [1:0] inc);
    logic [CWID:0] s;
    s = {1'b0, c} + {{(CWID-1){1'b0}}, inc};
    return s[CWID] ? '1 : s[CWID-1:0];
  endfunction

  assign used  = commit_addr - raddr;
  assign free  = '1 - used;
  assign admit = (free >= MAX_W);
  assign waddr = spec_ptr;

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    err_flag_nxt = err_flag;
    wr_nxt       = 1'b0;
    commit_nxt   = 1'b0;
    rb_late_nxt  = 1'b0;
    rb_now       = 1'b0;
    rej          = 1'b0;
    orphan       = 1'b0;
    eval_sop     = 1'b0;
    if (in_vld) begin
      case (state)
        IDLE: begin
          if (in_sop) eval_sop = 1'b1;
          else        orphan   = 1'b1;
        end
        WRITE: begin
          if (in_sop) begin
            rb_now   = 1'b1;
            eval_sop = 1'b1;
          end else if (in_eop) begin
            wr_nxt    = 1'b1;
            state_nxt = IDLE;
            if (err_flag | in_err) rb_late_nxt = 1'b1;
            else                   commit_nxt  = 1'b1;
          end else if (word_cnt == MAX_W) begin
            rb_now    = 1'b1;
            state_nxt = DROP;
          end else begin
            wr_nxt       = 1'b1;
            word_cnt_nxt = word_cnt + 1'b1;
            err_flag_nxt = err_flag | in_err;
          end
        end
        DROP: begin
          if (in_sop)      eval_sop  = 1'b1;
          else if (in_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // A SOP is judged the same way whichever state it arrives in.
    if (eval_sop) begin
      if (admit) begin
        wr_nxt       = 1'b1;
        word_cnt_nxt = AWID'(1);
        err_flag_nxt = in_err;
        if (in_eop) begin
          state_nxt = IDLE;
          if (in_err) rb_late_nxt = 1'b1;
          else        commit_nxt  = 1'b1;
        end else begin
          state_nxt = WRITE;
        end
      end else begin
        rej       = 1'b1;
        state_nxt = in_eop ? IDLE : DROP;
      end
    end
  end

  assign drop_inc = {1'b0, rb_now} + {1'b0, rb_late_nxt} + {1'b0, rej};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      err_flag     <= 1'b0;
      spec_ptr     <= '0;
      wen          <= 1'b0;
      wdata        <= '0;
      pend_commit  <= 1'b0;
      pend_rb      <= 1'b0;
      commit_addr  <= '0;
      commit_pulse <= 1'b0;
      drop_pulse   <= 1'b0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      orphan_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      word_cnt    <= word_cnt_nxt;
      err_flag    <= err_flag_nxt;
      wen         <= wr_nxt;
      if (wr_nxt) wdata <= in_data;
      pend_commit <= commit_nxt;
      pend_rb     <= rb_late_nxt;
      // Errored EOP words are still written, so their rewind lands one edge later.
      if (rb_now || pend_rb) spec_ptr <= commit_addr;
      else if (wen)          spec_ptr <= spec_ptr + 1'b1;
      if (pend_commit) begin
        commit_addr <= spec_ptr + 1'b1;
        pkt_ok_cnt  <= sat_add(pkt_ok_cnt, 2'd1);
      end
      commit_pulse <= pend_commit;
      drop_pulse   <= |drop_inc;
      pkt_drop_cnt <= sat_add(pkt_drop_cnt, drop_inc);
      if (orphan) orphan_cnt <= sat_add(orphan_cnt, 2'd1);
    end
  end

endmodule

// File: tb/tb_pkt_fifo_wr_admit.sv
// Scoreboard bench for pkt_fifo_wr_admit: expected RAM writes and commit
// pointers are queued as packets are driven and popped as the DUT emits them.
module tb_pkt_fifo_wr_admit;
  localparam int DW   = 64;
  localparam int AW   = 10;
  localparam int MAXW = 256;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] raddr = '0;
  logic          wen, commit_pulse, drop_pulse;
  logic [AW-1:0] waddr, commit_addr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] pkt_ok_cnt, pkt_drop_cnt, orphan_cnt;

  pkt_fifo_wr_admit #(.DWID(DW), .AWID(AW), .MAX_PKT_WORDS(MAXW), .CWID(CW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_err(in_err), .in_data(in_data), .raddr(raddr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .commit_addr(commit_addr), .commit_pulse(commit_pulse),
    .drop_pulse(drop_pulse), .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt),
    .orphan_cnt(orphan_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int m_ok = 0, m_drop = 0, m_orph = 0, n_dpulse = 0;
  logic [AW-1:0]    m_commit = '0;
  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0]    cm_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        if (wr_q.size() == 0) check_eq("unexpected_wen", wen, 1'b0);
        else begin
          logic [AW+DW-1:0] e;
          e = wr_q.pop_front();
          check_eq("waddr", waddr, e[AW+DW-1:DW]);
          check_eq("wdata", wdata, e[DW-1:0]);
        end
      end
      if (commit_pulse) begin
        if (cm_q.size() == 0) check_eq("unexpected_commit", commit_pulse, 1'b0);
        else check_eq("commit_addr", commit_addr, cm_q.pop_front());
      end
      if (drop_pulse) n_dpulse++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic s, input logic e, input logic er, input logic [DW-1:0] d);
    in_vld = 1'b1; in_sop = s; in_eop = e; in_err = er; in_data = d;
    @(posedge clk);
    #1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
  endtask

  // err_at is 1-based (0 = clean); no_eop leaves the packet open.
  task automatic send_pkt(input int len, input int err_at, input bit no_eop);
    logic [AW-1:0] used, free, sp;
    logic [DW-1:0] d;
    bit acc;
    used = m_commit - raddr;
    free = 10'h3FF - used;
    acc  = (int'(free) >= MAXW);
    sp   = m_commit;
    if (!acc) m_drop++;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (acc && i < MAXW) begin
        wr_q.push_back({sp, d});
        sp = sp + 1'b1;
      end
      beat(i == 0, (i == len - 1) && !no_eop, (i + 1) == err_at, d);
    end
    if (acc) begin
      if (len > MAXW || err_at != 0 || no_eop) m_drop++;
      else begin
        m_commit = m_commit + AW'(len);
        cm_q.push_back(m_commit);
        m_ok++;
      end
    end
  endtask

  task automatic check_cnts(input string tag);
    check_eq({tag, "_ok"},     pkt_ok_cnt,   m_ok);
    check_eq({tag, "_drop"},   pkt_drop_cnt, m_drop);
    check_eq({tag, "_orphan"}, orphan_cnt,   m_orph);
    check_eq({tag, "_caddr"},  commit_addr,  m_commit);
  endtask

  initial begin
    idle(3);
    check_eq("rst_wen", wen, 1'b0);
    check_eq("rst_waddr", waddr, '0);
    check_eq("rst_caddr", commit_addr, '0);
    check_eq("rst_pulses", {commit_pulse, drop_pulse}, 2'b00);
    check_eq("rst_cnts", {pkt_ok_cnt, pkt_drop_cnt}, '0);
    check_eq("rst_orphan", orphan_cnt, '0);
    rst = 1'b0;
    idle(2);

    send_pkt(4, 0, 0);            idle(3); check_cnts("basic");
    send_pkt(5, 2, 0);            idle(3); check_cnts("err");
    send_pkt(1, 0, 0);            idle(3);
    send_pkt(1, 1, 0);            idle(3); check_cnts("single");
    send_pkt(3, 0, 1);
    send_pkt(4, 0, 0);            idle(2);
    beat(1'b0, 1'b0, 1'b0, 64'hDEAD); m_orph++;
    idle(3);                              check_cnts("noeop");

    while (m_commit != AW'(900)) begin
      raddr = m_commit;
      send_pkt((900 - int'(m_commit)) > MAXW ? MAXW : 900 - int'(m_commit), 0, 0);
      idle(3);
    end
    raddr = '0; idle(2);
    send_pkt(10, 0, 0);           idle(3); check_cnts("reject");
    raddr = AW'(200); idle(2);
    send_pkt(10, 0, 0);           idle(3); check_cnts("admit");

    raddr = m_commit;
    send_pkt(300, 0, 0);          idle(3); check_cnts("oversize");

    raddr = m_commit;
    send_pkt(112, 0, 0);          idle(3);
    raddr = m_commit;
    send_pkt(3, 0, 0);            idle(4);
    check_eq("wrap_caddr", commit_addr, AW'(1));

    idle(5);
    check_cnts("final");
    check_eq("wr_q_left", wr_q.size(), 0);
    check_eq("cm_q_left", cm_q.size(), 0);
    check_eq("drop_pulses", n_dpulse, m_drop);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pkt_fifo_wr_admit.md
Name: pkt_fifo_wr_admit

Overview:
- Packet-aware write-side controller for the packet queue buffer. Single clock domain (`clk`).
- Accepts a framed word stream and writes it into the dual-port buffer RAM using a speculative pointer.
- Publishes a committed write pointer only after a complete, error-free packet has been written. That pointer feeds the Gray-code write-to-read crossing and the full/empty logic.
- Packets are admitted or rejected whole at SOP, based on free space. Packets that are errored, oversize or malformed are rolled back, so the reader never sees partial packets.

Parameters:
- DWID, 64, data word width
- AWID, 10, buffer address width (depth 2**AWID)
- MAX_PKT_WORDS, 256, largest legal packet in words; admission threshold; must be ≤ 2**AWID-1
- CWID, 32, width of statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_vld  in  1  input beat valid (no backpressure; every valid beat is consumed)
- in_sop  in  1  first word of packet
- in_eop  in  1  last word of packet
- in_err  in  1  error marker; sticky for the current packet
- in_data  in  DWID  input word
- raddr  in  AWID  read pointer, already converted to binary in the clk domain
- wen  out  1  RAM write enable
- waddr  out  AWID  RAM write address (speculative pointer)
- wdata  out  DWID  RAM write data
- commit_addr  out  AWID  committed write pointer
- commit_pulse  out  1  one-cycle pulse when commit_addr advances
- drop_pulse  out  1  one-cycle pulse when a packet is discarded
- pkt_ok_cnt  out  CWID  committed packets, saturating
- pkt_drop_cnt  out  CWID  discarded packets, saturating
- orphan_cnt  out  CWID  beats received outside a packet, saturating

Behaviour:
- Reset values: all outputs 0; spec_ptr = 0; word_cnt = 0; err_flag = 0; state = IDLE.
- Free space: used = commit_addr − raddr (mod 2**AWID); free = 2**AWID − 1 − used. One slot is always reserved, so used never reaches 2**AWID. Free is evaluated combinationally from the current registered commit_addr and raddr.
- Write latency: a beat sampled at edge T with a write decision drives wen=1, waddr=spec_ptr and wdata=in_data during cycle T+1. spec_ptr increments at edge T+1.
- States:
  - IDLE:
    - in_vld & in_sop & free ≥ MAX_PKT_WORDS → accept: write word, word_cnt=1, err_flag=in_err. If in_eop is also set, finish immediately (see commit rules); else go to WRITE.
    - in_vld & in_sop & free < MAX_PKT_WORDS → no write, drop_pulse, pkt_drop_cnt++. If in_eop is also set, stay IDLE; else go to DROP.
    - in_vld without in_sop → discard, orphan_cnt++.
  - WRITE:
    - in_vld & ~in_sop → write word, word_cnt++, err_flag |= in_err.
    - Beat with in_eop → finish.
    - Beat without in_eop when word_cnt == MAX_PKT_WORDS → oversize: rollback, then go to DROP.
    - in_vld & in_sop (missing EOP) → rollback the current packet. The new SOP beat is evaluated in the same cycle exactly as in IDLE.
  - DROP:
    - Discard beats until in_eop, then go to IDLE.
    - in_sop in DROP → evaluate as IDLE.
- Finish:
  - err_flag (including in_err on the EOP beat) = 0 → commit: commit_addr ← spec_ptr after the last write, updated at the same edge the last word is written. commit_pulse is high the following cycle; pkt_ok_cnt++.
  - err_flag = 1 → rollback.
- Rollback: spec_ptr ← commit_addr; no commit; drop_pulse; pkt_drop_cnt++. A rollback counts as one drop per packet, never twice.
- Ring overflow is impossible once a packet is admitted, because the reader only frees space. A packet of exactly MAX_PKT_WORDS words with EOP on the last word commits normally.
- Pointers wrap modulo 2**AWID.
- Counters saturate at all-ones.
- Reset mid-packet returns to IDLE and discards the in-flight packet without a drop count.

Test Plan:
- Empty buffer (raddr=0); 4-word packet with no error → wen on 4 consecutive cycles at waddr 0..3; commit_addr=4 one cycle after the last wen; commit_pulse once; pkt_ok_cnt=1.
- in_err on word 2 of a 5-word packet → 5 writes; commit_addr stays 0; drop_pulse; next packet writes from waddr 0.
- commit_addr=900, raddr=0, AWID=10 (free=123 < 256) → SOP rejected; no wen; pkt_drop_cnt=1. Raise raddr to 200 → next packet admitted.
- 300-word packet, MAX_PKT_WORDS=256 → 256 writes, rollback after word 257; remaining beats ignored until EOP; exactly one drop counted.
- SOP arriving while in WRITE, plus a beat outside any packet in IDLE → first packet rolled back, second committed starting at the rolled-back address; orphan_cnt=1.
- commit_addr=1022, with raddr advanced so the packet fits → 3-word packet writes 1022, 1023, 0; commit_addr=1.
